// File: rtl/operation_pkg.sv
// Shared types and defaults for the round-robin operation arbiter.
package operation_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2,
        REL       = 2'd3
    } op_state_t;

    localparam int BW_DEF  = 16;
    localparam int TMO_DEF = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt,
    output logic            vld
);

    int          off_idx;
    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the nearest one after ptr wins last.
    always_comb begin
        gnt     = '0;
        vld     = 1'b0;
        off_idx = 0;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            off_idx = (int'(ptr) + i) % NREQ;
            cand    = PW'(off_idx);
            if (req[cand]) begin
                gnt = cand;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operation_arbiter_rr.sv
// Round-robin arbiter/sequencer sharing one ST/RD operation unit among NREQ requesters.
// Optional watchdog: define OPERATION_ARBITER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no job; sample REQ and grant next requester
// WAIT_LOW  | OP_ST high, waiting for the unit to drop OP_RD
// WAIT_HIGH | waiting for OP_RD to return high (result ready)
// REL       | DONE strobe cycle, OP_ST held low before next grant
module operation_arbiter_rr
    import operation_pkg::*;
#(
    parameter int BW   = BW_DEF,
    parameter int NREQ = 4,
    parameter int TMO  = TMO_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*BW-1:0] A_IN0,
    input  logic [NREQ*BW-1:0] A_IN1,
    output logic [NREQ-1:0]   DONE,
    output logic [BW-1:0]     RESULT,
    output logic              BUSY,
    output logic              ERR,
    output logic              OP_ST,
    output logic [BW-1:0]     OP_IN0,
    output logic [BW-1:0]     OP_IN1,
    input  logic              OP_RD,
    input  logic [BW-1:0]     OP_RES
);

    localparam int PW = $clog2(NREQ);

    op_state_t     state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt, grant, grant_nxt;
    logic [PW-1:0] pick_gnt;
    logic          pick_vld;
    logic          tmo_hit;

    logic [NREQ-1:0] done_nxt;
    logic [BW-1:0]   result_nxt, op_in0_nxt, op_in1_nxt;
    logic            busy_nxt, err_nxt, op_st_nxt;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

`ifdef OPERATION_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;

    // Down-counter reloaded on every state change; zero while waiting means no progress for TMO cycles.
    always_ff @(posedge CLK) begin
        if (RST || (state_nxt != state))
            tmo_cnt <= CW'(TMO - 1);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
    end

    assign tmo_hit = ((state == WAIT_LOW) || (state == WAIT_HIGH)) && (tmo_cnt == '0);
`else
    logic unused_tmo;
    assign unused_tmo = (TMO > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= PW'(NREQ - 1);
            grant  <= '0;
            DONE   <= '0;
            RESULT <= '0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
            OP_ST  <= 1'b0;
            OP_IN0 <= '0;
            OP_IN1 <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            DONE   <= done_nxt;
            RESULT <= result_nxt;
            BUSY   <= busy_nxt;
            ERR    <= err_nxt;
            OP_ST  <= op_st_nxt;
            OP_IN0 <= op_in0_nxt;
            OP_IN1 <= op_in1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_vld) state_nxt = WAIT_LOW;
            WAIT_LOW:  if (!OP_RD) state_nxt = WAIT_HIGH;
                       else if (tmo_hit) state_nxt = REL;
            WAIT_HIGH: if (OP_RD || tmo_hit) state_nxt = REL;
            REL:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done_nxt   = '0;
        err_nxt    = 1'b0;
        result_nxt = RESULT;
        op_st_nxt  = OP_ST;
        op_in0_nxt = OP_IN0;
        op_in1_nxt = OP_IN1;
        ptr_nxt    = ptr;
        grant_nxt  = grant;
        busy_nxt   = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt  = pick_gnt;
                    ptr_nxt    = pick_gnt;
                    op_in0_nxt = A_IN0[int'(pick_gnt)*BW +: BW];
                    op_in1_nxt = A_IN1[int'(pick_gnt)*BW +: BW];
                    op_st_nxt  = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (OP_RD && tmo_hit) begin
                    done_nxt[grant] = 1'b1;
                    err_nxt         = 1'b1;
                    op_st_nxt       = 1'b0;
                end
            end
            WAIT_HIGH: begin
                if (OP_RD) begin
                    result_nxt      = OP_RES;
                    done_nxt[grant] = 1'b1;
                    op_st_nxt       = 1'b0;
                end else if (tmo_hit) begin
                    done_nxt[grant] = 1'b1;
                    err_nxt         = 1'b1;
                    op_st_nxt       = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_operation_arbiter_rr.sv
// Scoreboard bench for operation_arbiter_rr; the unit model returns IN1 and pulses RD low once per ST rise.
module tb_operation_arbiter_rr;

    typedef struct {
        logic [3:0]  done;
        logic [15:0] res;
        logic        err;
        logic [15:0] in0;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } direct_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = '0;
    logic [63:0] A_IN0 = '0;
    logic [63:0] A_IN1 = '0;
    logic [3:0]  DONE;
    logic [15:0] RESULT;
    logic        BUSY, ERR, OP_ST;
    logic [15:0] OP_IN0, OP_IN1;
    logic        OP_RD = 1'b1;
    logic [15:0] OP_RES;

    logic st_d  = 1'b0;
    logic stuck = 1'b0;
    logic op_st_q = 1'b0;
    int   st_rises = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t    sb[$];
    direct_t dq[$];

    operation_arbiter_rr #(.BW(16), .NREQ(4), .TMO(15)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN0(A_IN0), .A_IN1(A_IN1),
        .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY), .ERR(ERR), .OP_ST(OP_ST),
        .OP_IN0(OP_IN0), .OP_IN1(OP_IN1), .OP_RD(OP_RD), .OP_RES(OP_RES)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign OP_RES = OP_IN1;
    always @(posedge CLK) begin
        if (RST) begin
            st_d  <= 1'b0;
            OP_RD <= 1'b1;
        end else begin
            st_d  <= OP_ST;
            OP_RD <= stuck | !(OP_ST && !st_d);
        end
    end

    // Monitor: all comparisons happen here.
    always @(negedge CLK) begin
        exp_t    e;
        direct_t d;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                errors++;
                $display("FAIL %s act=%0h exp=%0h", d.name, d.act, d.exp);
            end
        end
        if (OP_ST && !op_st_q) st_rises++;
        op_st_q = OP_ST;
        if (DONE != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done act=%b exp=none at cyc %0d", DONE, cyc);
            end else begin
                e = sb.pop_front();
                checks += 5;
                if (DONE !== e.done) begin errors++; $display("FAIL done_vec act=%b exp=%b", DONE, e.done); end
                if (RESULT !== e.res) begin errors++; $display("FAIL result act=%h exp=%h", RESULT, e.res); end
                if (ERR !== e.err) begin errors++; $display("FAIL err act=%b exp=%b", ERR, e.err); end
                if (OP_IN0 !== e.in0) begin errors++; $display("FAIL op_in0 act=%h exp=%h", OP_IN0, e.in0); end
                if (cyc != e.cyc) begin errors++; $display("FAIL done_cycle act=%0d exp=%0d", cyc, e.cyc); end
            end
        end else if (ERR) begin
            checks++;
            errors++;
            $display("FAIL err_without_done act=1 exp=0");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        direct_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dq.push_back(d);
    endtask

    task automatic expect_done(input logic [3:0] dv, input logic [15:0] res, input logic err,
                               input logic [15:0] in0, input int at);
        exp_t e;
        e.done = dv; e.res = res; e.err = err; e.in0 = in0; e.cyc = at;
        sb.push_back(e);
    endtask

    // Drive REQ just after an edge; returns the cycle count at drive time.
    task automatic go(input logic [3:0] r, output int c);
        @(posedge CLK);
        #1;
        REQ = r;
        c = cyc;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge CLK);
            t++;
            if (DONE != '0) seen++;
        end
        if (seen < n) chk("wait_done_timeout", seen, n);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_op_st", OP_ST, 0);
        chk("rst_op_in0", OP_IN0, 0);
        chk("rst_op_in1", OP_IN1, 0);
        RST = 1'b0;

        // Single request from requester 0
        A_IN0[15:0] = 16'h5555;
        A_IN1[15:0] = 16'h1234;
        go(4'b0001, c);
        expect_done(4'b0001, 16'h1234, 1'b0, 16'h5555, c + 4);
        wait_dones(1, 20);
        REQ = '0;
        repeat (3) @(negedge CLK);
        chk("st_pulses_single", st_rises, 1);
        chk("idle_busy", BUSY, 0);

        // All four requesting continuously from a fresh pointer
        for (int i = 0; i < 4; i++) begin
            A_IN0[i*16 +: 16] = 16'(16'h0B00 + i);
            A_IN1[i*16 +: 16] = 16'(16'h00A0 + i);
        end
        do_reset();
        go(4'b1111, c);
        expect_done(4'b0001, 16'h00A0, 1'b0, 16'h0B00, c + 4);
        expect_done(4'b0010, 16'h00A1, 1'b0, 16'h0B01, c + 9);
        expect_done(4'b0100, 16'h00A2, 1'b0, 16'h0B02, c + 14);
        expect_done(4'b1000, 16'h00A3, 1'b0, 16'h0B03, c + 19);
        expect_done(4'b0001, 16'h00A0, 1'b0, 16'h0B00, c + 24);
        wait_dones(5, 60);
        REQ = '0;

        // Move pointer to 1, then 1010 must serve 3 before 1
        go(4'b0010, c);
        expect_done(4'b0010, 16'h00A1, 1'b0, 16'h0B01, c + 4);
        wait_dones(1, 20);
        REQ = '0;
        go(4'b1010, c);
        expect_done(4'b1000, 16'h00A3, 1'b0, 16'h0B03, c + 4);
        expect_done(4'b0010, 16'h00A1, 1'b0, 16'h0B01, c + 9);
        wait_dones(1, 20);
        REQ[3] = 1'b0;
        wait_dones(1, 20);
        REQ = '0;

        // Reset while in WAIT_HIGH aborts the job for requester 2
        go(4'b0100, c);
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_wait_high", BUSY, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_done", DONE, 0);
        chk("abort_op_st", OP_ST, 0);
        chk("abort_busy", BUSY, 0);
        RST = 1'b0;
        REQ = 4'b0101;
        c = cyc;
        expect_done(4'b0001, 16'h00A0, 1'b0, 16'h0B00, c + 4);
        expect_done(4'b0100, 16'h00A2, 1'b0, 16'h0B02, c + 9);
        wait_dones(1, 20);
        REQ[0] = 1'b0;
        wait_dones(1, 20);
        REQ = '0;

        // Unit RD stuck high
        stuck = 1'b1;
        go(4'b0001, c);
`ifdef OPERATION_ARBITER_TIMEOUT_EN
        expect_done(4'b0001, 16'h00A2, 1'b1, 16'h0B00, c + 16);
        wait_dones(1, 40);
        REQ = '0;
        repeat (3) @(negedge CLK);
        chk("tmo_busy_after", BUSY, 0);
`else
        repeat (40) @(negedge CLK);
        chk("stuck_busy", BUSY, 1);
        chk("stuck_result", RESULT, 16'h00A2);
        REQ = '0;
`endif
        stuck = 1'b0;
        do_reset();
        repeat (3) @(negedge CLK);
        chk("sb_left", sb.size(), 0);
        repeat (2) @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
